// File: rtl/mul_pkg.sv
// Shared types and defaults for the EXE-stage MUL/DIV path.
// The divider wrapper reuses these constants.
package mul_pkg;

    localparam int MUL_WIDTH_DEF = 32;
    localparam int MUL_LAT_DEF   = 2;
    localparam int MUL_TAG_W_DEF = 5;

    typedef struct packed {
        logic                       is_signed;
        logic [MUL_WIDTH_DEF-1:0]   a;
        logic [MUL_WIDTH_DEF-1:0]   b;
        logic [MUL_TAG_W_DEF-1:0]   tag;
    } mul_req_t;

    typedef struct packed {
        logic [2*MUL_WIDTH_DEF-1:0] p;
        logic [MUL_TAG_W_DEF-1:0]   tag;
    } mul_rsp_t;

endpackage

// File: rtl/mul_pipe_stage.sv
// One multiplier pipeline stage: valid/product/tag register with load, hold and clear.
// Reset is synchronous and active-low; clear drops only the valid bit.
module mul_pipe_stage
    import mul_pkg::*;
#(
    parameter int DATA_W = 2 * MUL_WIDTH_DEF,
    parameter int TAG_W  = MUL_TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_p,
    input  logic [TAG_W-1:0]  src_tag,
    output logic              valid,
    output logic [DATA_W-1:0] p,
    output logic [TAG_W-1:0]  tag
);

    // NOTE: data and tag are reset too (not just valid) so the outputs read 0 after reset;
    // all state uses non-blocking assignments so stages shift without ordering races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            p     <= '0;
            tag   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            p     <= src_p;
            tag   <= src_tag;
        end
    end

endmodule

// File: rtl/pipe_multiplier.sv
// Pipelined signed/unsigned WIDTHxWIDTH multiplier with valid/ready and bubble collapsing.
// Define MUL_FLUSH_EN to add the flush port that squashes all in-flight operations.
module pipe_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF,
    parameter int LAT   = MUL_LAT_DEF,
    parameter int TAG_W = MUL_TAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef MUL_FLUSH_EN
    input  logic               flush,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);

    logic               squash;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;

    logic [LAT-1:0]     st_valid;
    logic [LAT-1:0]     adv;
    logic [LAT-1:0]     load;
    logic [LAT-1:0]     src_valid;
    logic [2*WIDTH-1:0] st_p    [LAT];
    logic [2*WIDTH-1:0] src_p   [LAT];
    logic [TAG_W-1:0]   st_tag  [LAT];
    logic [TAG_W-1:0]   src_tag [LAT];

`ifdef MUL_FLUSH_EN
    assign squash = flush;
`else
    assign squash = 1'b0;
`endif

    // Sign-extending to 2*WIDTH and keeping the low half matches the exact
    // (WIDTH+1)x(WIDTH+1) product in both modes.
    always_comb begin
        a_ext   = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
        b_ext   = {{WIDTH{in_signed & in_b[WIDTH-1]}}, in_b};
        product = a_ext * b_ext;
    end

    always_comb begin
        adv[LAT-1] = out_ready | ~st_valid[LAT-1];
        for (int i = LAT - 2; i >= 0; i--) begin
            adv[i] = adv[i+1] | ~st_valid[i+1];
        end
    end

    // An empty stage always loads, which is what collapses bubbles.
    assign load     = adv | ~st_valid;
    assign in_ready = load[0];

    for (genvar i = 0; i < LAT; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign src_valid[i] = in_valid & in_ready;
            assign src_p[i]     = product;
            assign src_tag[i]   = in_tag;
        end else begin : g_body
            assign src_valid[i] = st_valid[i-1];
            assign src_p[i]     = st_p[i-1];
            assign src_tag[i]   = st_tag[i-1];
        end

        mul_pipe_stage #(
            .DATA_W (2 * WIDTH),
            .TAG_W  (TAG_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .clear     (squash),
            .src_valid (src_valid[i]),
            .src_p     (src_p[i]),
            .src_tag   (src_tag[i]),
            .valid     (st_valid[i]),
            .p         (st_p[i]),
            .tag       (st_tag[i])
        );
    end

    assign out_valid = st_valid[LAT-1];
    assign out_p     = st_p[LAT-1];
    assign out_tag   = st_tag[LAT-1];

endmodule

// File: doc/pipe_multiplier.md
# pipe_multiplier

Parametrised, pipelined integer multiplier for the EXE stage MUL/DIV path. It multiplies two WIDTH-bit operands, signed or unsigned per operation, and returns a 2*WIDTH-bit product after LAT cycles. A valid/ready handshake with bubble collapsing lets back-pressure from the HI/LO writeback stall the pipe without losing operations. An optional flush squashes in-flight work on exceptions and branch mispredicts.

## Interface
- WIDTH, 32: operand width in bits; legal range 8..64.
- LAT, 2: pipeline depth in stages; also the minimum latency. Legal range 1..4.
- TAG_W, 5: width of the sideband tag carried alongside each operation.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the block can accept an operation this cycle.
- in_signed  in  1  1 selects signed×signed; 0 selects unsigned×unsigned.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- flush  in  1  squash all in-flight operations. Present only with MUL_FLUSH_EN.
- out_valid  out  1  a result is available.
- out_ready  in  1  the consumer takes the result.
- out_p  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Stages S0..S(LAT-1). Each stage holds valid, p[2*WIDTH-1:0] and tag.
- Arithmetic:
  - Each operand is extended to WIDTH+1 bits; the extension bit is in_signed & msb.
  - The (WIDTH+1)×(WIDTH+1) product is formed and truncated to its low 2*WIDTH bits. The result is exact for both modes.
  - The product is computed combinationally into S0. Later stages only delay it.
- Advance rule, evaluated per stage:
  - adv(LAT-1) = out_ready | ~valid(LAT-1).
  - adv(i) = adv(i+1) | ~valid(i+1) for i < LAT-1.
  - in_ready = adv(0) | ~valid(0).
  - Bubbles collapse: an empty stage always accepts from the stage upstream of it.
- Stage load:
  - When stage i advances, it loads the stage upstream of it. S0 loads the input; its valid becomes in_valid & in_ready.
  - When stage i does not advance, it holds its content.
- Outputs: out_valid = valid(LAT-1); out_p and out_tag come from S(LAT-1).
  - While out_valid=1 and out_ready=0, out_p and out_tag stay stable.
- Flush (MUL_FLUSH_EN):
  - All valid bits clear at the next edge.
  - An input presented in the same cycle as flush is dropped. in_ready may still read 1 in that cycle.
  - Flush takes priority over every advance.
- Reset (rst=0 at an edge):
  - All valid bits are 0, so out_valid=0 and in_ready=1 in the following cycle.
  - Data and tag registers are also cleared to 0, so out_p=0 and out_tag=0 after reset.
  - Reset mid-operation discards all in-flight operations.

## Timing
- Latency: an operation accepted at edge t gives out_valid=1 in the cycle after edge t+LAT-1, provided there is no back-pressure.
- Throughput: 1 operation per cycle.
- A full pipe with out_ready=0 gives in_ready=0.
- A full pipe with out_ready=1 accepts and emits in the same cycle.
- Occupancy never exceeds LAT. No ordering change: results leave in acceptance order.
- in_ready depends combinationally on out_ready through the adv chain. No other combinational input-to-output path exists.

## Configuration
- MUL_FLUSH_EN defined: the flush port exists and has the behaviour above.
- MUL_FLUSH_EN undefined:
  - No flush port.
  - Valid bits clear only on reset.
  - Gate count and the adv-chain logic are otherwise identical.

## Structure
- Shared package mul_pkg holds:
  - typedef mul_req_t {signed, a, b, tag};
  - typedef mul_rsp_t {p, tag};
  - constants MUL_WIDTH_DEF=32 and MUL_LAT_DEF=2, reused by the divider wrapper.
- One sub-module, mul_pipe_stage: a single valid/data/tag register with load, hold and clear. It is instantiated LAT times via generate.
- Product formation stays in the top level so it can later be replaced by an IP or Booth tree.

## Test plan
- Unsigned, WIDTH=32, LAT=2: a=0xFFFFFFFF, b=0xFFFFFFFF, in_signed=0 -> out_p=0xFFFFFFFE00000001 two cycles after acceptance; tag is preserved.
- Signed: a=0xFFFFFFFF (−1), b=0x00000003, in_signed=1 -> out_p=0xFFFFFFFFFFFFFFFD. Signed: a=0x80000000, b=0x80000000 -> out_p=0x4000000000000000.
- Streaming with back-pressure:
  - Issue 6 back-to-back operations with tags 1..6 while out_ready toggles 1,0,0,1...
  - Required: in_ready=0 only while the pipe is full and out_ready=0.
  - Required: tags emerge in order 1..6, with no duplication or loss.
- Bubble collapse, LAT=3:
  - One operation accepted; out_ready=0 held for 5 cycles.
  - Required: the operation parks in S2 and in_ready stays 1 until 3 operations are held.
- Flush (MUL_FLUSH_EN): 2 operations in flight plus a new input, with flush=1 for one cycle -> out_valid=0 for the next LAT cycles and no result appears for any of the 3.
- Reset mid-stream: rst=0 for one edge with the pipe full -> the next cycle has out_valid=0, in_ready=1, out_p=0, and a new operation completes normally.
